branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch/flow-control unit sitting directly upstream of the fetch stage. It takes the current instruction word from program ROM and the current PC from fetch. It produces the TYPE field, the branch-taken flag `B1_OUT` and the target `PC_VAL` that fetch consumes on its next clock edge. It holds the condition flags (Z, C) and a hardware return-address stack for CALL/RET.

## Interface
- `DEPTH`, 8: return-stack entries (power of two, ≥2).
- `clk` in 1: system clock; all state updates on rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `INSTR` in 18: instruction word; `INSTR[17:11]` = TYPE, `INSTR[10:0]` = ADDR.
- `VALID` in 1: `INSTR` is a real instruction this cycle.
- `PC` in 11: current fetch PC (address of `INSTR`).
- `FLAG_WE` in 1: load flags from ALU this cycle.
- `Z_IN` in 1: ALU zero result.
- `C_IN` in 1: ALU carry result.
- `TYPE` out 7: `INSTR[17:11]`, passed through combinationally.
- `B1_OUT` out 1: flow change taken (combinational).
- `PC_VAL` out 11: target PC (combinational).
- `ZF`, `CF` out 1 each: registered flags.
- `STK_OVF` out 1: sticky, CALL attempted with stack full.
- `STK_UNF` out 1: sticky, RET attempted with stack empty.

## Operation
- Flow instruction ⇔ `TYPE[6]=1`. Sub-op is `TYPE[2:0]`:
  - 000 JMP: always taken.
  - 001 JZ: taken if ZF.
  - 010 JNZ: taken if !ZF.
  - 011 JC: taken if CF.
  - 100 JNC: taken if !CF.
  - 101 CALL: always taken.
  - 110 RET: taken if stack non-empty.
  - 111: never taken.
- `TYPE[5:3]` is ignored for flow instructions.
- `B1_OUT` = `VALID & TYPE[6] & cond`. It is 0 whenever `TYPE[6]=0`, `VALID=0` or `nreset=0`.
- `PC_VAL`:
  - RET: top-of-stack entry.
  - All other instructions: ADDR.
  - `PC_VAL` is only meaningful when `B1_OUT=1`.
- Conditions use the registered ZF/CF, i.e. the values before this edge. There is no bypass from `Z_IN`/`C_IN`.
- Flag register: on an edge with `FLAG_WE=1`, ZF←`Z_IN` and CF←`C_IN`. This is independent of `VALID` and of the instruction.
- Return stack: SP counts 0..DEPTH.
  - CALL with `VALID` and SP<DEPTH: push `(PC+1) mod 2048` and SP+1. PC=2047 pushes 0.
  - CALL with SP=DEPTH: jump still taken, no push, SP unchanged, `STK_OVF`←1.
  - RET with `VALID` and SP>0: `PC_VAL`=top, pop, SP−1.
  - RET with SP=0: not taken (`B1_OUT=0`, fetch falls through), SP unchanged, `STK_UNF`←1.
  - `VALID=0`: no push, no pop, no sticky update.
- Sticky flags clear only on reset.
- Reset (async, `nreset=0`): SP=0, ZF=0, CF=0, `STK_OVF`=0, `STK_UNF`=0. Stack contents are don't-care. While held in reset, `B1_OUT`=0.

## Timing
- `TYPE`, `B1_OUT` and `PC_VAL` are purely combinational from `INSTR`, `VALID`, `PC` and registered state. They must settle within the cycle so fetch samples them on the same rising edge.
- Push/pop, flag load and sticky updates take effect on that same rising edge. They are visible to the next instruction in the following cycle.
- Zero-cycle branch latency. An instruction presented at cycle n redirects PC at edge n.
- Back-to-back CALL/RET in consecutive cycles is legal. RET immediately after CALL returns the just-pushed address.
- Reset asserted mid-CALL/RET: the state returns to reset values asynchronously, and that edge's push/pop is discarded.
- Reset release coinciding with a clock edge: no state update on that edge.

## Test plan
- **Reset:** pulse `nreset` low between edges → ZF=CF=0, `STK_OVF`=`STK_UNF`=0, `B1_OUT`=0. A RET right after reset gives `B1_OUT`=0 and `STK_UNF`=1.
- **Conditional jump:** `FLAG_WE`=1, `Z_IN`=1 with a JZ to 0x123 in the same cycle → not taken (old ZF=0). Next cycle, JZ to 0x123 → `B1_OUT`=1, `PC_VAL`=0x123. JNZ → `B1_OUT`=0.
- **Call/return:** CALL 0x200 at PC=0x010 → taken, `PC_VAL`=0x200. RET at PC=0x205 → `PC_VAL`=0x011. Also CALL at PC=0x7FF followed by RET → `PC_VAL`=0x000.
- **Nesting:** DEPTH=8 CALLs at PCs 0..7 → 8 RETs return 8,7,…,1 in LIFO order. A 9th CALL → still taken, `STK_OVF`=1, and the stack still returns 8..1.
- **VALID gating:** `VALID`=0 with a JMP/CALL/RET present → `B1_OUT`=0, SP unchanged, stickies unchanged.
- **Non-flow instruction:** `TYPE`=0x05 → `B1_OUT`=0, `TYPE` output = 0x05. `TYPE`=0x47 (sub-op 111) → `B1_OUT`=0.

Source files
------------

// File: rtl/branch_ctrl.sv
// Branch/flow-control unit ahead of fetch: decodes flow ops, holds Z/C flags and a
// hardware return-address stack, and drives a same-cycle redirect (B1_OUT/PC_VAL).
module branch_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [17:0] INSTR,
  input  logic        VALID,
  input  logic [10:0] PC,
  input  logic        FLAG_WE,
  input  logic        Z_IN,
  input  logic        C_IN,
  output logic [6:0]  TYPE,
  output logic        B1_OUT,
  output logic [10:0] PC_VAL,
  output logic        ZF,
  output logic        CF,
  output logic        STK_OVF,
  output logic        STK_UNF
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so SP can represent the full (DEPTH) state.
  localparam int unsigned SpW  = IdxW + 1;

  typedef enum logic [2:0] {
    OpJmp  = 3'b000,
    OpJz   = 3'b001,
    OpJnz  = 3'b010,
    OpJc   = 3'b011,
    OpJnc  = 3'b100,
    OpCall = 3'b101,
    OpRet  = 3'b110,
    OpNop  = 3'b111
  } flow_op_e;

  logic [SpW-1:0]  sp_q, sp_d;
  logic            zf_q, zf_d;
  logic            cf_q, cf_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [10:0]     stack_q [DEPTH];

  logic [10:0]     addr;
  logic            is_flow;
  flow_op_e        op;
  logic            cond;
  logic            stk_empty;
  logic            stk_full;
  logic [SpW-1:0]  sp_dec;
  logic [IdxW-1:0] top_idx;
  logic [IdxW-1:0] push_idx;
  logic [10:0]     top_val;
  logic [10:0]     pc_inc;
  logic            act_call;
  logic            act_ret;
  logic            push;
  logic            pop;

  assign TYPE    = INSTR[17:11];
  assign addr    = INSTR[10:0];
  assign is_flow = INSTR[17];
  assign op      = flow_op_e'(INSTR[13:11]);

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SpW'(DEPTH));
  assign sp_dec    = sp_q - SpW'(1);
  assign top_idx   = sp_dec[IdxW-1:0];
  assign push_idx  = sp_q[IdxW-1:0];
  assign top_val   = stack_q[top_idx];
  assign pc_inc    = PC + 11'd1;

  // Conditions look only at registered flags; Z_IN/C_IN are never bypassed.
  always_comb begin
    cond = 1'b0;
    unique case (op)
      OpJmp:  cond = 1'b1;
      OpJz:   cond = zf_q;
      OpJnz:  cond = ~zf_q;
      OpJc:   cond = cf_q;
      OpJnc:  cond = ~cf_q;
      OpCall: cond = 1'b1;
      OpRet:  cond = ~stk_empty;
      OpNop:  cond = 1'b0;
    endcase
  end

  assign act_call = nreset & VALID & is_flow & (op == OpCall);
  assign act_ret  = nreset & VALID & is_flow & (op == OpRet);
  assign push     = act_call & ~stk_full;
  assign pop      = act_ret & ~stk_empty;

  // Redirect outputs; gated by nreset so nothing is taken while held in reset.
  always_comb begin
    B1_OUT = nreset & VALID & is_flow & cond;
    PC_VAL = addr;
    if (is_flow && (op == OpRet)) begin
      PC_VAL = top_val;
    end
  end

  always_comb begin
    sp_d  = sp_q;
    zf_d  = zf_q;
    cf_d  = cf_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (FLAG_WE) begin
      zf_d = Z_IN;
      cf_d = C_IN;
    end
    if (push) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop) begin
      sp_d = sp_dec;
    end
    if (act_call && stk_full) begin
      ovf_d = 1'b1;
    end
    if (act_ret && stk_empty) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sp_q  <= '0;
      zf_q  <= 1'b0;
      cf_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      zf_q  <= zf_d;
      cf_q  <= cf_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset: entries above SP are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign ZF      = zf_q;
  assign CF      = cf_q;
  assign STK_OVF = ovf_q;
  assign STK_UNF = unf_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed test-plan steps followed by random
// instruction streams, all checked against a queue-based reference model.
module tb_branch_ctrl;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [17:0] INSTR = '0;
  logic        VALID = 1'b0;
  logic [10:0] PC = '0;
  logic        FLAG_WE = 1'b0;
  logic        Z_IN = 1'b0;
  logic        C_IN = 1'b0;
  logic [6:0]  TYPE;
  logic        B1_OUT;
  logic [10:0] PC_VAL;
  logic        ZF, CF, STK_OVF, STK_UNF;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_stk[$];
  bit m_zf, m_cf, m_ovf, m_unf;

  always #5 clk = ~clk;

  branch_ctrl #(.DEPTH(D)) dut (
    .clk(clk), .nreset(nreset), .INSTR(INSTR), .VALID(VALID), .PC(PC),
    .FLAG_WE(FLAG_WE), .Z_IN(Z_IN), .C_IN(C_IN), .TYPE(TYPE), .B1_OUT(B1_OUT),
    .PC_VAL(PC_VAL), .ZF(ZF), .CF(CF), .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; presents one instruction, checks it and the resulting state.
  task automatic step(input logic [6:0] ty, input logic [10:0] ad, input logic v,
                      input logic [10:0] pc, input logic fwe, input logic z, input logic c,
                      input string tag, output logic ob1, output logic [10:0] opc);
    bit taken, cnd;
    int exp_pc;
    INSTR = {ty, ad}; VALID = v; PC = pc; FLAG_WE = fwe; Z_IN = z; C_IN = c;
    #2;
    case (ty[2:0])
      3'd0: cnd = 1;
      3'd1: cnd = m_zf;
      3'd2: cnd = !m_zf;
      3'd3: cnd = m_cf;
      3'd4: cnd = !m_cf;
      3'd5: cnd = 1;
      3'd6: cnd = (m_stk.size() > 0);
      default: cnd = 0;
    endcase
    taken = v && ty[6] && cnd;
    exp_pc = (ty[2:0] == 3'd6 && m_stk.size() > 0) ? m_stk[$] : int'(ad);
    ob1 = B1_OUT; opc = PC_VAL;
    chk({tag, "/type"}, 32'(TYPE), 32'(ty));
    chk({tag, "/b1"}, 32'(B1_OUT), 32'(taken));
    if (taken) chk({tag, "/pcval"}, 32'(PC_VAL), 32'(exp_pc));
    @(posedge clk);
    if (fwe) begin m_zf = z; m_cf = c; end
    if (v && ty[6] && ty[2:0] == 3'd5) begin
      if (m_stk.size() < D) m_stk.push_back((int'(pc) + 1) % 2048);
      else m_ovf = 1;
    end
    if (v && ty[6] && ty[2:0] == 3'd6) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1;
    end
    #1;
    chk({tag, "/zf"}, 32'(ZF), 32'(m_zf));
    chk({tag, "/cf"}, 32'(CF), 32'(m_cf));
    chk({tag, "/ovf"}, 32'(STK_OVF), 32'(m_ovf));
    chk({tag, "/unf"}, 32'(STK_UNF), 32'(m_unf));
  endtask

  // Pulse reset between edges with a JMP presented; starts and ends at posedge+1.
  task automatic do_reset(input string tag);
    INSTR = {7'h40, 11'h155}; VALID = 1'b1; FLAG_WE = 1'b0;
    nreset = 1'b0;
    #2;
    chk({tag, "/b1"}, 32'(B1_OUT), 32'd0);
    chk({tag, "/zf"}, 32'(ZF), 32'd0);
    chk({tag, "/cf"}, 32'(CF), 32'd0);
    chk({tag, "/ovf"}, 32'(STK_OVF), 32'd0);
    chk({tag, "/unf"}, 32'(STK_UNF), 32'd0);
    m_stk.delete(); m_zf = 0; m_cf = 0; m_ovf = 0; m_unf = 0;
    VALID = 1'b0;
    #1 nreset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic b1;
    logic [10:0] pv;
    logic [6:0] ty;

    @(posedge clk); #1;
    do_reset("rst0");

    // RET right after reset: not taken, underflow sticky set
    step(7'h46, 11'h0, 1, 11'h000, 0, 0, 0, "ret_empty", b1, pv);
    chk("ret_empty_b1", 32'(b1), 32'd0);
    chk("ret_empty_unf", 32'(STK_UNF), 32'd1);
    do_reset("rst1");

    // Flag load in the same cycle as JZ does not affect that JZ
    step(7'h41, 11'h123, 1, 11'h020, 1, 1, 0, "jz_old", b1, pv);
    chk("jz_old_b1", 32'(b1), 32'd0);
    step(7'h41, 11'h123, 1, 11'h021, 0, 0, 0, "jz_new", b1, pv);
    chk("jz_new_b1", 32'(b1), 32'd1);
    chk("jz_new_pc", 32'(pv), 32'h123);
    step(7'h42, 11'h123, 1, 11'h022, 0, 0, 0, "jnz", b1, pv);
    chk("jnz_b1", 32'(b1), 32'd0);

    // Call/return including PC wrap
    step(7'h45, 11'h200, 1, 11'h010, 0, 0, 0, "call", b1, pv);
    chk("call_pc", 32'(pv), 32'h200);
    step(7'h46, 11'h000, 1, 11'h205, 0, 0, 0, "ret", b1, pv);
    chk("ret_pc", 32'(pv), 32'h011);
    step(7'h45, 11'h300, 1, 11'h7FF, 0, 0, 0, "call_wrap", b1, pv);
    step(7'h46, 11'h000, 1, 11'h300, 0, 0, 0, "ret_wrap", b1, pv);
    chk("ret_wrap_b1", 32'(b1), 32'd1);
    chk("ret_wrap_pc", 32'(pv), 32'h000);

    // Nesting to full depth, then one overflow CALL
    for (int i = 0; i < D; i++) step(7'h45, 11'h400, 1, 11'(i), 0, 0, 0, "nest_call", b1, pv);
    step(7'h45, 11'h500, 1, 11'h050, 0, 0, 0, "ovf_call", b1, pv);
    chk("ovf_call_b1", 32'(b1), 32'd1);
    chk("ovf_call_pc", 32'(pv), 32'h500);
    chk("ovf_sticky", 32'(STK_OVF), 32'd1);
    for (int i = 0; i < D; i++) begin
      step(7'h46, 11'h000, 1, 11'h600, 0, 0, 0, "nest_ret", b1, pv);
      chk("nest_ret_pc", 32'(pv), 32'(D - i));
    end

    // VALID gating
    step(7'h45, 11'h111, 1, 11'h0AA, 0, 0, 0, "vg_setup", b1, pv);
    step(7'h40, 11'h222, 0, 11'h0AB, 0, 0, 0, "vg_jmp", b1, pv);
    chk("vg_jmp_b1", 32'(b1), 32'd0);
    step(7'h45, 11'h222, 0, 11'h0AC, 0, 0, 0, "vg_call", b1, pv);
    step(7'h46, 11'h000, 0, 11'h0AD, 0, 0, 0, "vg_ret", b1, pv);
    chk("vg_ret_b1", 32'(b1), 32'd0);
    step(7'h46, 11'h000, 1, 11'h0AE, 0, 0, 0, "vg_ret_real", b1, pv);
    chk("vg_ret_real_pc", 32'(pv), 32'h0AB);

    // Non-flow and never-taken sub-op
    step(7'h05, 11'h333, 1, 11'h0B0, 0, 0, 0, "nonflow", b1, pv);
    chk("nonflow_b1", 32'(b1), 32'd0);
    step(7'h47, 11'h333, 1, 11'h0B1, 0, 0, 0, "subop7", b1, pv);
    chk("subop7_b1", 32'(b1), 32'd0);

    // Randomized streams, with an occasional reset pulse
    do_reset("rst2");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rst_rand");
      if ($urandom_range(0, 3) == 0) ty = {1'b0, 6'($urandom)};
      else ty = {1'b1, 3'($urandom), 3'($urandom_range(0, 7))};
      // Bias toward CALL/RET so the stack visits both ends
      if (ty[6] && $urandom_range(0, 1) == 1) ty[2:0] = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd6;
      step(ty, 11'($urandom), ($urandom_range(0, 7) != 0), 11'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), "rand", b1, pv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
